// File: rtl/loader_pkg.sv
// loader_pkg
// Shared types and constants for the serial boot loader.
//   loader_state_t : frame-parsing FSM states used by boot_loader
//   rx_state_t     : bit-level states used by uart_rx
//   SYNC_BYTE      : opens a load frame
//   GO_BYTE        : releases the core from reset
//   clks_per_bit() : clock cycles per serial bit, rounded to nearest
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RUN
    } loader_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] GO_BYTE   = 8'h5A;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/boot_loader_uart_rx.sv
// uart_rx
// 8N1 serial receiver for the boot loader.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   rx       : asynchronous serial input, idle high
//   rx_byte  : last byte received with a valid stop bit
//   rx_valid : one-cycle pulse when rx_byte is updated
//   rx_ferr  : one-cycle pulse when a stop bit was sampled low
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LIM = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LIM = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta;
    logic            rx_sync;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    // Two-flop synchroniser; both stages reset to the idle level so a
    // reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit timing. The start bit is re-checked at half a bit so a glitch
    // is rejected, and every later sample lands mid-bit. After a framing
    // error the line may still be low, so we wait for it to go high before
    // hunting for the next start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LIM) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LIM) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LIM) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                            state    <= RX_IDLE;
                        end else begin
                            rx_ferr <= 1'b1;
                            state   <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader
// Receives framed program images over a UART and writes them into the
// 6502 core's program memory, holding the core in reset until told to go.
// Frame: A5, ADDR_H, ADDR_L, LEN (0 = 256), LEN data bytes, CSUM (sum of data).
// Command: 5A in IDLE releases the core.
//   clk       : system clock (shared with the core)
//   rst_n     : asynchronous active-low reset
//   rx        : serial input, idle high
//   ld_addr   : memory write address
//   ld_data   : memory write data
//   ld_we     : one-cycle memory write strobe
//   cpu_rst_n : core reset, active-low
//   busy      : high while a frame is being parsed
//   err       : sticky error, cleared by the next SYNC byte
module boot_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] ld_addr,
    output logic [7:0]  ld_data,
    output logic        ld_we,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CLKS - 1);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;

    loader_state_t state;
    logic [7:0]    addr_hi;
    logic [15:0]   cur_addr;
    logic [8:0]    remaining;
    logic [7:0]    csum;
    logic [TW-1:0] timer;
    logic          in_frame;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign in_frame = (state != ST_IDLE) && (state != ST_RUN);

    // Frame parser. cur_addr is the running write pointer; ld_addr only
    // changes on a write so the memory side sees a stable address/data
    // pair between strobes. A completed or aborted frame always lands in
    // IDLE, which keeps the core in reset until an explicit GO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ld_addr   <= '0;
            ld_data   <= '0;
            ld_we     <= 1'b0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            addr_hi   <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            csum      <= '0;
            timer     <= '0;
        end else begin
            ld_we <= 1'b0;
            if (rx_valid) begin
                timer <= '0;
                unique case (state)
                    ST_IDLE, ST_RUN: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state     <= ST_ADDR_H;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                            cpu_rst_n <= 1'b0;
                        end else if (rx_byte == GO_BYTE && state == ST_IDLE) begin
                            state     <= ST_RUN;
                            cpu_rst_n <= 1'b1;
                        end
                    end
                    ST_ADDR_H: begin
                        addr_hi <= rx_byte;
                        state   <= ST_ADDR_L;
                    end
                    ST_ADDR_L: begin
                        cur_addr <= {addr_hi, rx_byte};
                        state    <= ST_LEN;
                    end
                    ST_LEN: begin
                        remaining <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                        csum      <= '0;
                        state     <= ST_DATA;
                    end
                    ST_DATA: begin
                        ld_addr   <= cur_addr;
                        ld_data   <= rx_byte;
                        ld_we     <= 1'b1;
                        cur_addr  <= cur_addr + 16'd1;
                        remaining <= remaining - 9'd1;
                        csum      <= csum + rx_byte;
                        if (remaining == 9'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (rx_byte != csum) begin
                            err <= 1'b1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (rx_ferr) begin
                // A corrupt byte outside a frame only flags the error; inside
                // a frame the rest of the frame can no longer be trusted.
                timer <= '0;
                err   <= 1'b1;
                if (in_frame) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end else if (in_frame) begin
                if (timer == TIMEOUT_LIM) begin
                    timer <= '0;
                    err   <= 1'b1;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader
// Directed bench for boot_loader. The loader runs at 8 clocks per bit
// (1 MHz / 125 kBd) so a full 256-byte frame stays short.
module tb_boot_loader;

    localparam int BIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_we;
    logic        cpu_rst_n;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          we_count = 0;
    bit          we_double = 0;
    logic        we_prev = 1'b0;
    logic        busy_prev = 1'b0;
    logic        rst_at_busy_rise = 1'b1;

    always #5 clk = ~clk;

    boot_loader #(
        .CLK_HZ       (1000000),
        .BAUD         (125000),
        .TIMEOUT_BITS (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_we     (ld_we),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .err       (err)
    );

    // Write log and edge observations, sampled on the falling edge.
    always @(negedge clk) begin
        if (ld_we === 1'b1) begin
            wa.push_back(ld_addr);
            wd.push_back(ld_data);
            we_count++;
            if (we_prev === 1'b1) we_double = 1;
        end
        we_prev = ld_we;
        if (busy === 1'b1 && busy_prev !== 1'b1) rst_at_busy_rise = cpu_rst_n;
        busy_prev = busy;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        we_count = 0;
        we_double = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        clear_log();
        repeat (5) @(negedge clk);
        checks++;
        if ({ld_addr, ld_data, ld_we, cpu_rst_n, busy, err} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got addr=%h data=%h we=%b crst=%b busy=%b err=%b expected all 0",
                     ld_addr, ld_data, ld_we, cpu_rst_n, busy, err);
        end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (cpu_rst_n !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got crst=%b busy=%b err=%b expected 0 0 0", cpu_rst_n, busy, err);
        end
        checks++;
        if (we_count !== 0) begin
            errors++;
            $display("[TB] FAIL no_write_idle: got %0d writes expected 0", we_count);
        end
    endtask

    task automatic test_load_basic();
        logic [7:0] frame [8] = '{8'hA5, 8'h02, 8'h00, 8'h03, 8'hA9, 8'h42, 8'h00, 8'hEB};
        logic [15:0] exp_a [3] = '{16'h0200, 16'h0201, 16'h0202};
        logic [7:0]  exp_d [3] = '{8'hA9, 8'h42, 8'h00};
        clear_log();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (we_count !== 3 || we_double) begin
            errors++;
            $display("[TB] FAIL basic_write_count: got %0d (double=%0d) expected 3 single strobes", we_count, we_double);
        end
        if (wa.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
                    errors++;
                    $display("[TB] FAIL basic_write%0d: got %h=%h expected %h=%h", i, wa[i], wd[i], exp_a[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (ld_addr !== 16'h0202 || ld_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL basic_hold: got %h=%h expected 0202=00", ld_addr, ld_data);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || cpu_rst_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_end: got err=%b busy=%b crst=%b expected 0 0 0", err, busy, cpu_rst_n);
        end
    endtask

    task automatic test_go_reload();
        logic [7:0] tail [4] = '{8'h30, 8'h00, 8'h01, 8'h07};
        clear_log();
        send_byte(8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL go_release: got crst=%b busy=%b expected 1 0", cpu_rst_n, busy);
        end
        rst_at_busy_rise = 1'b1;
        send_byte(8'hA5, 1'b1);
        checks++;
        if (rst_at_busy_rise !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_reset: got crst_at_accept=%b busy=%b expected 0 1", rst_at_busy_rise, busy);
        end
        foreach (tail[i]) send_byte(tail[i], 1'b1);
        send_byte(8'h07, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (we_count !== 1 || ld_addr !== 16'h3000 || ld_data !== 8'h07 || err !== 1'b0 || cpu_rst_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_frame: got n=%0d %h=%h err=%b crst=%b expected 1 3000=07 0 0",
                     we_count, ld_addr, ld_data, err, cpu_rst_n);
        end
    endtask

    // Ends with a fresh SYNC accepted, leaving the loader waiting for ADDR_H.
    task automatic test_bad_csum_wrap();
        logic [7:0] frame [7] = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h00};
        clear_log();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 2 || wa[0] !== 16'hFFFF || wd[0] !== 8'h11 || wa[1] !== 16'h0000 || wd[1] !== 8'h22) begin
            errors++;
            $display("[TB] FAIL wrap_writes: got n=%0d expected FFFF=11 0000=22", wa.size());
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_csum_err: got err=%b busy=%b expected 1 0", err, busy);
        end
        send_byte(8'hA5, 1'b1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_clears_err: got err=%b busy=%b expected 0 1", err, busy);
        end
    endtask

    task automatic test_long_frame();
        int bad_idx = -1;
        clear_log();
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (we_count !== 256 || we_double) begin
            errors++;
            $display("[TB] FAIL long_count: got %0d (double=%0d) expected 256", we_count, we_double);
        end
        for (int i = 0; i < wa.size() && i < 256; i++) begin
            if (bad_idx < 0 && (wa[i] !== 16'h1000 + 16'(i) || wd[i] !== 8'h01)) bad_idx = i;
        end
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("[TB] FAIL long_contents: write %0d got %h=%h expected %h=01",
                     bad_idx, wa[bad_idx], wd[bad_idx], 16'h1000 + 16'(bad_idx));
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_end: got err=%b busy=%b expected 0 0", err, busy);
        end
    endtask

    task automatic test_timeout();
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (440) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL before_timeout: got busy=%b err=%b expected 1 0", busy, err);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || we_count !== 0) begin
            errors++;
            $display("[TB] FAIL after_timeout: got busy=%b err=%b n=%0d expected 0 1 0", busy, err, we_count);
        end
    endtask

    task automatic test_framing();
        send_byte(8'hA5, 1'b1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL framing_sync: got err=%b busy=%b expected 0 1", err, busy);
        end
        send_byte(8'h04, 1'b1);
        send_byte(8'h77, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL framing_abort: got busy=%b err=%b expected 0 1", busy, err);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] frame [6] = '{8'hA5, 8'h20, 8'h00, 8'h04, 8'hAA, 8'hBB};
        clear_log();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        checks++;
        if (busy !== 1'b1 || ld_addr !== 16'h2001 || ld_data !== 8'hBB || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_data: got busy=%b %h=%h err=%b expected 1 2001=BB 0", busy, ld_addr, ld_data, err);
        end
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ld_addr, ld_data, ld_we, cpu_rst_n, busy, err} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got addr=%h data=%h we=%b crst=%b busy=%b err=%b expected all 0",
                     ld_addr, ld_data, ld_we, cpu_rst_n, busy, err);
        end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || we_count !== 2) begin
            errors++;
            $display("[TB] FAIL after_async_reset: got busy=%b n=%0d expected 0 2", busy, we_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_go_reload();
        test_bad_csum_wrap();
        test_long_frame();
        test_timeout();
        test_framing();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
